// File: rtl/exp_table_loader_pkg.sv
// Shared definitions for the exponent-table loader: state encoding, data width, default table sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exp_table_loader_pkg;

  localparam int DATA_WIDTH         = 18;  // 3 integer / 15 fractional bits
  localparam int DEFAULT_PATH_WIDTH = 10;  // sigma table: 2^10 entries
  localparam int DEFAULT_LOG_T      = 9;   // mu table: 2^9 entries
  localparam int CHECKSUM_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_SIGMA = 2'd1,
    LOAD_MU    = 2'd2,
    WAIT_SWAP  = 2'd3
  } loaderState_t;

endpackage

// File: rtl/exp_table_loader_addr_counter.sv
// Write-address counter for one table: clears to 0, advances by one per accepted word.
// Latency: count updates on the edge after iIncr; oLast is combinational from the count.
// Backpressure: none; the caller gates iIncr with its own accept.
module load_addr_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iClear,
  input  logic             iIncr,
  output logic [WIDTH-1:0] oCount,
  output logic             oLast
);

  // Address register; clear has priority so a new set always starts at entry 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oCount <= '0;
    end else if (iClear) begin
      oCount <= '0;
    end else if (iIncr) begin
      oCount <= oCount + WIDTH'(1);
    end
  end

  // Last entry of the table is reached when every address bit is set.
  assign oLast = &oCount;

endmodule

// File: rtl/exp_table_loader.sv
// Streams a sigma table then a mu table into the inactive buffer and flips oSwitch once a core is done.
// Latency: accepted word appears on its write port one cycle later; swap one edge after WAIT_SWAP is seen with a done.
// Backpressure: oReady high only while loading; words offered in IDLE/WAIT_SWAP stall upstream. Optional oChecksum under LOADER_CHECKSUM_EN.
module exp_table_loader
  import exp_table_loader_pkg::*;
#(
  parameter int PATH_WIDTH = DEFAULT_PATH_WIDTH,
  parameter int LOG_T      = DEFAULT_LOG_T
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iCoreDone,
  output logic [PATH_WIDTH-1:0] oSigmaWriteAddress,
  output logic [DATA_WIDTH-1:0] oSigmaWriteData,
  output logic                  oSigmaWE,
  output logic [LOG_T-1:0]      oMuWriteAddress,
  output logic [DATA_WIDTH-1:0] oMuWriteData,
  output logic                  oMuWE,
  output logic                  oSwitch,
  output logic                  oSwapped,
  output logic                  oBusy
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0] oChecksum
`endif
);

  loaderState_t state;
  loaderState_t stateNext;

  logic                  startLoad;
  logic                  swapNow;
  logic                  accept;
  logic                  sigmaAccept;
  logic                  muAccept;
  logic                  pendingDone;
  logic [PATH_WIDTH-1:0] sigmaCount;
  logic                  sigmaLast;
  logic [LOG_T-1:0]      muCount;
  logic                  muLast;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake decode; iStart is only looked at in IDLE, so it can never race a swap.
  always_comb begin
    stateNext = state;
    oReady    = 1'b0;
    startLoad = 1'b0;
    swapNow   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          stateNext = LOAD_SIGMA;
          startLoad = 1'b1;
        end
      end
      LOAD_SIGMA: begin
        oReady = 1'b1;
        if (iValid && sigmaLast) begin
          stateNext = LOAD_MU;
        end
      end
      LOAD_MU: begin
        oReady = 1'b1;
        if (iValid && muLast) begin
          stateNext = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        // The last mu write is on its port while we sit here, so the earliest swap
        // edge is already after that write.
        if (pendingDone || iCoreDone) begin
          swapNow   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign accept      = iValid && oReady;
  assign sigmaAccept = accept && (state == LOAD_SIGMA);
  assign muAccept    = accept && (state == LOAD_MU);
  assign oBusy       = (state != IDLE);

  load_addr_counter #(
    .WIDTH (PATH_WIDTH)
  ) uSigmaCounter (
    .CLK    (CLK),
    .RST    (RST),
    .iClear (startLoad),
    .iIncr  (sigmaAccept),
    .oCount (sigmaCount),
    .oLast  (sigmaLast)
  );

  load_addr_counter #(
    .WIDTH (LOG_T)
  ) uMuCounter (
    .CLK    (CLK),
    .RST    (RST),
    .iClear (startLoad),
    .iIncr  (muAccept),
    .oCount (muCount),
    .oLast  (muLast)
  );

  // Sigma write port: one-cycle registered copy of the accepted word and its address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oSigmaWE           <= 1'b0;
      oSigmaWriteAddress <= '0;
      oSigmaWriteData    <= '0;
    end else begin
      oSigmaWE <= sigmaAccept;
      if (sigmaAccept) begin
        oSigmaWriteAddress <= sigmaCount;
        oSigmaWriteData    <= iData;
      end
    end
  end

  // Mu write port: same registered timing as the sigma port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oMuWE           <= 1'b0;
      oMuWriteAddress <= '0;
      oMuWriteData    <= '0;
    end else begin
      oMuWE <= muAccept;
      if (muAccept) begin
        oMuWriteAddress <= muCount;
        oMuWriteData    <= iData;
      end
    end
  end

  // Buffer select and done bookkeeping. pendingDone comes out of reset set because
  // no core is running yet, so the very first set may go live immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oSwitch     <= 1'b0;
      oSwapped    <= 1'b0;
      pendingDone <= 1'b1;
    end else begin
      oSwapped <= swapNow;
      if (swapNow) begin
        oSwitch     <= ~oSwitch;
        pendingDone <= 1'b0;
      end else if (iCoreDone) begin
        pendingDone <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of every accepted word; restarts with each new set and holds afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oChecksum <= '0;
    end else if (startLoad) begin
      oChecksum <= '0;
    end else if (accept) begin
      oChecksum <= oChecksum + CHECKSUM_WIDTH'(iData);
    end
  end
`endif

endmodule

// File: tb/tb_exp_table_loader.sv
// Scoreboard bench for exp_table_loader with 8-entry sigma and 4-entry mu tables.
// Latency: expected writes are queued when a word is offered and retired when the write enable shows.
// Backpressure: words are only offered while the loader should be loading; oReady is checked each time.
module tb_exp_table_loader;

  localparam int PW = 3;
  localparam int LT = 2;
  localparam int NSIG = 1 << PW;
  localparam int NMU = 1 << LT;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iStart;
  logic [17:0]   iData;
  logic          iValid;
  logic          oReady;
  logic          iCoreDone;
  logic [PW-1:0] oSigmaWriteAddress;
  logic [17:0]   oSigmaWriteData;
  logic          oSigmaWE;
  logic [LT-1:0] oMuWriteAddress;
  logic [17:0]   oMuWriteData;
  logic          oMuWE;
  logic          oSwitch;
  logic          oSwapped;
  logic          oBusy;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   oChecksum;
`endif

  exp_table_loader #(
    .PATH_WIDTH (PW),
    .LOG_T      (LT)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .iStart             (iStart),
    .iData              (iData),
    .iValid             (iValid),
    .oReady             (oReady),
    .iCoreDone          (iCoreDone),
    .oSigmaWriteAddress (oSigmaWriteAddress),
    .oSigmaWriteData    (oSigmaWriteData),
    .oSigmaWE           (oSigmaWE),
    .oMuWriteAddress    (oMuWriteAddress),
    .oMuWriteData       (oMuWriteData),
    .oMuWE              (oMuWE),
    .oSwitch            (oSwitch),
    .oSwapped           (oSwapped),
    .oBusy              (oBusy)
`ifdef LOADER_CHECKSUM_EN
    ,
    .oChecksum          (oChecksum)
`endif
  );

  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nMismatched = 0;
  int cycle = 0;
  int sigWeCnt = 0;
  int muWeCnt = 0;
  int swapCount = 0;
  int swapCycle = 0;
  int lastMuCycle = 0;
  int sigIdx = 0;
  int muIdx = 0;
  logic expSwitch = 1'b0;

  logic [PW+17:0] sigQ[$];
  logic [LT+17:0] muQ[$];

  always @(posedge CLK) cycle <= cycle + 1;

  // Retire expected writes as they appear and note swap pulses.
  always @(negedge CLK) begin
    logic [PW+17:0] es;
    logic [LT+17:0] em;
    if (oSigmaWE === 1'b1) begin
      sigWeCnt++;
      nCompared++;
      if (sigQ.size() == 0) begin
        nMismatched++;
        $display("FAIL sigma_unexpected_write: got addr %0d data %05h, expected no write", oSigmaWriteAddress, oSigmaWriteData);
      end else begin
        es = sigQ.pop_front();
        if ({oSigmaWriteAddress, oSigmaWriteData} !== es) begin
          nMismatched++;
          $display("FAIL sigma_write: got addr %0d data %05h, expected addr %0d data %05h",
                   oSigmaWriteAddress, oSigmaWriteData, es[PW+17:18], es[17:0]);
        end
      end
    end
    if (oMuWE === 1'b1) begin
      muWeCnt++;
      lastMuCycle = cycle;
      nCompared++;
      if (muQ.size() == 0) begin
        nMismatched++;
        $display("FAIL mu_unexpected_write: got addr %0d data %05h, expected no write", oMuWriteAddress, oMuWriteData);
      end else begin
        em = muQ.pop_front();
        if ({oMuWriteAddress, oMuWriteData} !== em) begin
          nMismatched++;
          $display("FAIL mu_write: got addr %0d data %05h, expected addr %0d data %05h",
                   oMuWriteAddress, oMuWriteData, em[LT+17:18], em[17:0]);
        end
      end
    end
    if (oSwapped === 1'b1) begin
      swapCount++;
      swapCycle = cycle;
    end
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic startSet();
    iStart = 1'b1;
    @(posedge CLK); #1;
    iStart = 1'b0;
    sigIdx = 0;
    muIdx  = 0;
  endtask

  task automatic sendWord(input logic [17:0] d, input bit gap);
    iValid = 1'b1;
    iData  = d;
    @(negedge CLK);
    nCompared++;
    if (oReady !== 1'b1) begin
      nMismatched++;
      $display("FAIL ready_while_loading: got %b, expected 1", oReady);
    end
    if (sigIdx < NSIG) begin
      sigQ.push_back({PW'(sigIdx), d});
      sigIdx++;
    end else begin
      muQ.push_back({LT'(muIdx), d});
      muIdx++;
    end
    @(posedge CLK); #1;
    iValid = 1'b0;
    iData  = '0;
    if (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulseCoreDone();
    iCoreDone = 1'b1;
    @(posedge CLK); #1;
    iCoreDone = 1'b0;
  endtask

  // Bounded wait for the swap counter to move past prev; returns on a falling edge.
  task automatic waitSwap(input int prev, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (swapCount != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; iStart = 1'b0; iData = '0; iValid = 1'b0; iCoreDone = 1'b0;
    repeat (3) @(negedge CLK);
    nCompared++;
    if ({oBusy, oReady, oSwitch, oSwapped, oSigmaWE, oMuWE} !== 6'b0) begin
      nMismatched++;
      $display("FAIL reset_flags: got busy/ready/switch/swapped/swe/mwe %b, expected 000000",
               {oBusy, oReady, oSwitch, oSwapped, oSigmaWE, oMuWE});
    end
    nCompared++;
    if ({oSigmaWriteAddress, oSigmaWriteData, oMuWriteAddress, oMuWriteData} !== '0) begin
      nMismatched++;
      $display("FAIL reset_write_ports: got sa %0d sd %05h ma %0d md %05h, expected all 0",
               oSigmaWriteAddress, oSigmaWriteData, oMuWriteAddress, oMuWriteData);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Common end-of-set checks after a swap is expected.
  task automatic test_first_set();
    int s0, m0, sw0;
    bit ok;
    s0 = sigWeCnt; m0 = muWeCnt; sw0 = swapCount;
    startSet();
    for (int i = 1; i <= 12; i++) sendWord(18'(i), 1'b0);
    waitSwap(sw0, ok);
    repeat (3) @(negedge CLK);
    expSwitch = ~expSwitch;
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL first_swap_timeout: got no swap, expected swap without core done"); end
    nCompared++;
    if (swapCount !== sw0 + 1) begin nMismatched++; $display("FAIL first_swap_pulses: got %0d, expected %0d", swapCount - sw0, 1); end
    nCompared++;
    if (oSwitch !== expSwitch) begin nMismatched++; $display("FAIL first_switch: got %b, expected %b", oSwitch, expSwitch); end
    nCompared++;
    if (swapCycle !== lastMuCycle + 1) begin nMismatched++; $display("FAIL first_swap_timing: got cycle %0d, expected %0d", swapCycle, lastMuCycle + 1); end
    nCompared++;
    if ((sigWeCnt - s0) !== NSIG || (muWeCnt - m0) !== NMU) begin
      nMismatched++;
      $display("FAIL first_we_counts: got %0d/%0d, expected %0d/%0d", sigWeCnt - s0, muWeCnt - m0, NSIG, NMU);
    end
    nCompared++;
    if (sigQ.size() != 0 || muQ.size() != 0 || oBusy !== 1'b0) begin
      nMismatched++;
      $display("FAIL first_drain: got pending %0d/%0d busy %b, expected 0/0 busy 0", sigQ.size(), muQ.size(), oBusy);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_wait_core();
    int sw0;
    sw0 = swapCount;
    startSet();
    for (int i = 0; i < 12; i++) sendWord(18'h00100 + 18'(i), 1'b0);
    repeat (6) @(negedge CLK);
    nCompared++;
    if ({oBusy, oReady, oSwitch} !== {1'b1, 1'b0, expSwitch} || swapCount !== sw0) begin
      nMismatched++;
      $display("FAIL wait_swap_hold: got busy %b ready %b switch %b swaps %0d, expected 1 0 %b 0",
               oBusy, oReady, oSwitch, swapCount - sw0, expSwitch);
    end
    @(posedge CLK); #1;
    pulseCoreDone();
    expSwitch = ~expSwitch;
    nCompared++;
    if (oSwitch !== expSwitch || oSwapped !== 1'b1) begin
      nMismatched++;
      $display("FAIL core_done_swap: got switch %b swapped %b, expected %b 1", oSwitch, oSwapped, expSwitch);
    end
    repeat (2) @(negedge CLK);
    nCompared++;
    if (swapCount !== sw0 + 1 || oBusy !== 1'b0 || sigQ.size() != 0 || muQ.size() != 0) begin
      nMismatched++;
      $display("FAIL core_done_after: got swaps %0d busy %b pending %0d/%0d, expected 1 0 0/0",
               swapCount - sw0, oBusy, sigQ.size(), muQ.size());
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_early_done();
    int sw0;
    bit ok;
    sw0 = swapCount;
    startSet();
    for (int i = 0; i < 3; i++) sendWord(18'h00400 + 18'(i), 1'b0);
    pulseCoreDone();
    for (int i = 3; i < 12; i++) sendWord(18'h00400 + 18'(i), 1'b0);
    waitSwap(sw0, ok);
    expSwitch = ~expSwitch;
    repeat (2) @(negedge CLK);
    nCompared++;
    if (!ok || oSwitch !== expSwitch) begin
      nMismatched++;
      $display("FAIL early_done_swap: got swapped %b switch %b, expected 1 %b", ok, oSwitch, expSwitch);
    end
    nCompared++;
    if (swapCycle !== lastMuCycle + 1) begin nMismatched++; $display("FAIL early_done_timing: got cycle %0d, expected %0d", swapCycle, lastMuCycle + 1); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midload();
    int sw0;
    bit ok;
    startSet();
    for (int i = 0; i < 5; i++) sendWord(18'h00500 + 18'(i), 1'b0);
    RST = 1'b1;
    #1;
    nCompared++;
    if ({oBusy, oReady, oSwitch, oSwapped, oSigmaWE, oMuWE} !== 6'b0 ||
        {oSigmaWriteAddress, oSigmaWriteData, oMuWriteAddress, oMuWriteData} !== '0) begin
      nMismatched++;
      $display("FAIL midload_reset: got busy/ready/switch/swapped/swe/mwe %b sa %0d sd %05h, expected 000000 0 00000",
               {oBusy, oReady, oSwitch, oSwapped, oSigmaWE, oMuWE}, oSigmaWriteAddress, oSigmaWriteData);
    end
    sigQ.delete();
    muQ.delete();
    expSwitch = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    sw0 = swapCount;
    startSet();
    for (int i = 0; i < 12; i++) sendWord(18'h00600 + 18'(i), 1'b0);
    waitSwap(sw0, ok);
    expSwitch = ~expSwitch;
    repeat (2) @(negedge CLK);
    nCompared++;
    if (!ok || oSwitch !== expSwitch || sigQ.size() != 0 || muQ.size() != 0) begin
      nMismatched++;
      $display("FAIL restart_after_reset: got swapped %b switch %b pending %0d/%0d, expected 1 %b 0/0",
               ok, oSwitch, sigQ.size(), muQ.size(), expSwitch);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_gaps();
    int s0, m0, sw0;
    bit ok;
    s0 = sigWeCnt; m0 = muWeCnt; sw0 = swapCount;
    startSet();
    for (int i = 0; i < 12; i++) sendWord(18'h00200 + 18'(i), 1'b1);
    pulseCoreDone();
    waitSwap(sw0, ok);
    expSwitch = ~expSwitch;
    repeat (2) @(negedge CLK);
    nCompared++;
    if ((sigWeCnt - s0) !== NSIG || (muWeCnt - m0) !== NMU) begin
      nMismatched++;
      $display("FAIL gap_we_counts: got %0d/%0d, expected %0d/%0d", sigWeCnt - s0, muWeCnt - m0, NSIG, NMU);
    end
    nCompared++;
    if (!ok || oSwitch !== expSwitch || sigQ.size() != 0 || muQ.size() != 0) begin
      nMismatched++;
      $display("FAIL gap_swap: got swapped %b switch %b pending %0d/%0d, expected 1 %b 0/0",
               ok, oSwitch, sigQ.size(), muQ.size(), expSwitch);
    end
    @(posedge CLK); #1;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int sw0;
    bit ok;
    sw0 = swapCount;
    startSet();
    nCompared++;
    if (oChecksum !== 32'h0) begin nMismatched++; $display("FAIL checksum_clear: got %08h, expected 00000000", oChecksum); end
    for (int i = 0; i < 12; i++) sendWord(18'h3FFFF, 1'b0);
    pulseCoreDone();
    waitSwap(sw0, ok);
    expSwitch = ~expSwitch;
    repeat (2) @(negedge CLK);
    nCompared++;
    if (!ok || oChecksum !== 32'h002FFFF4) begin
      nMismatched++;
      $display("FAIL checksum_sum: got %08h swapped %b, expected 002ffff4 1", oChecksum, ok);
    end
    @(posedge CLK); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_first_set();
    test_wait_core();
    test_early_done();
    test_reset_midload();
    test_gaps();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
